plru_victim_select: RTL

Tree pseudo-LRU replacement unit for the 8-way L2 cache model. It keeps per-set replacement state and updates it on every cache hit. On request it chooses the way to fill on a miss, preferring invalid lines. Its `victim_way` output drives the 3-bit `select` of the downstream 8-to-1 way multiplexor.

---
 rtl/plru_victim_select.sv | 119 +++++++++++
 1 files changed

// File: rtl/plru_victim_select.sv
// Tree pseudo-LRU replacement unit for an 8-way cache: per-set 7-bit trees updated on hits,
// plus a small FSM that picks a fill victim (invalid lines first) and makes it MRU.
module plru_victim_select #(
  parameter int WAYS     = 8,
  parameter int SET_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    touch_valid,
  input  logic [SET_BITS-1:0]     touch_set,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  input  logic                    victim_req,
  input  logic [SET_BITS-1:0]     victim_set,
  input  logic [WAYS-1:0]         victim_valid_mask,
  output logic                    victim_ready,
  output logic                    victim_done,
  output logic [$clog2(WAYS)-1:0] victim_way,
  output logic                    victim_was_invalid
);

  localparam int SETS = 1 << SET_BITS;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  logic [6:0]          tree [SETS];
  logic [SET_BITS-1:0] lat_set;
  logic [WAYS-1:0]     lat_mask;

  logic [6:0] calc_tree;
  logic [2:0] tree_way;
  logic [2:0] inv_way;
  logic       has_invalid;
  logic [6:0] done_base;

  // Point every node on the path of w away from w, so the walk avoids it.
  function automatic logic [6:0] touch_tree(input logic [6:0] t, input logic [2:0] w);
    logic [6:0] r;
    logic [2:0] leaf;
    r    = t;
    r[0] = ~w[2];
    if (w[2]) r[2] = ~w[1];
    else      r[1] = ~w[1];
    leaf    = 3'd3 + {1'b0, w[2:1]};
    r[leaf] = ~w[0];
    return r;
  endfunction

  always_comb begin
    logic       d2;
    logic       d1;
    logic [2:0] leaf;
    calc_tree = tree[lat_set];
    d2        = calc_tree[0];
    d1        = d2 ? calc_tree[2] : calc_tree[1];
    leaf      = 3'd3 + {1'b0, d2, d1};
    tree_way  = {d2, d1, calc_tree[leaf]};
  end

  // Scan downward so the lowest-index invalid way ends up selected.
  always_comb begin
    inv_way     = '0;
    has_invalid = ~&lat_mask;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!lat_mask[i]) inv_way = i[2:0];
    end
  end

  // A same-cycle hit to the victim's set is folded in first so the victim path overrides it.
  always_comb begin
    done_base = tree[lat_set];
    if (touch_valid && touch_set == lat_set) done_base = touch_tree(tree[lat_set], touch_way);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) tree[s] <= '0;
    end else begin
      if (touch_valid) tree[touch_set] <= touch_tree(tree[touch_set], touch_way);
      if (state == DONE) tree[lat_set] <= touch_tree(done_base, victim_way);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      lat_set            <= '0;
      lat_mask           <= '0;
      victim_ready       <= 1'b1;
      victim_done        <= 1'b0;
      victim_way         <= '0;
      victim_was_invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (victim_req) begin
            lat_set      <= victim_set;
            lat_mask     <= victim_valid_mask;
            victim_ready <= 1'b0;
            state        <= CALC;
          end
        end
        CALC: begin
          victim_way         <= has_invalid ? inv_way : tree_way;
          victim_was_invalid <= has_invalid;
          victim_done        <= 1'b1;
          state              <= DONE;
        end
        DONE: begin
          victim_done  <= 1'b0;
          victim_ready <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
